// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads one word per fetch from the
// memory controller, and hands it to the decoder over a valid/ready handshake.
// A read that the controller flags as out of range becomes a sticky fault.
// Branch redirects from downstream override any fetch in progress.
//
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   mem_addr       read address to controller (= pc)
//   mem_we         write enable to controller (always 0)
//   mem_data       write data to controller (always 0)
//   mem_value      read data from controller
//   mem_ready      mem_value is valid for mem_addr
//   mem_error      mem_addr is out of range
//   instr          registered fetched instruction
//   instr_valid    instr is valid
//   instr_ready    downstream accepts instr
//   branch_en      single-cycle redirect request
//   branch_target  redirect address
//   pc             address of next or in-flight fetch
//   fault          sticky fetch fault
//   fault_pc       address that faulted
module fetch_unit #(
    parameter int          DATA_WIDTH = 16,
    parameter int          ADDR_WIDTH = 4,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_value,
    input  logic                  mem_ready,
    input  logic                  mem_error,
    output logic [DATA_WIDTH-1:0] instr,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic                  branch_en,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  fault,
    output logic [ADDR_WIDTH-1:0] fault_pc
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_HOLD,
        S_FAULT
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] PC_RST = ADDR_WIDTH'(RESET_PC);
    localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   pc_q;
    logic [DATA_WIDTH-1:0]   instr_q;
    logic                    valid_q;
    logic                    fault_q;
    logic [ADDR_WIDTH-1:0]   fault_pc_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            pc_q       <= PC_RST;
            instr_q    <= '0;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    // Controller has not seen the address yet, so its
                    // ready/error are stale here and ignored.
                    if (branch_en) begin
                        pc_q    <= branch_target;
                        state_q <= S_FETCH;
                    end else begin
                        state_q <= S_WAIT;
                    end
                    valid_q <= 1'b0;
                end
                S_WAIT: begin
                    // Redirect beats both error and data; the read is dropped.
                    if (branch_en) begin
                        pc_q    <= branch_target;
                        valid_q <= 1'b0;
                        state_q <= S_FETCH;
                    end else if (mem_error) begin
                        fault_q    <= 1'b1;
                        fault_pc_q <= pc_q;
                        valid_q    <= 1'b0;
                        state_q    <= S_FAULT;
                    end else if (mem_ready) begin
                        instr_q <= mem_value;
                        valid_q <= 1'b1;
                        pc_q    <= pc_q + PC_ONE;
                        state_q <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    // A redirect drops a not-yet-accepted instruction.
                    if (branch_en) begin
                        pc_q    <= branch_target;
                        valid_q <= 1'b0;
                        state_q <= S_FETCH;
                    end else if (instr_ready) begin
                        valid_q <= 1'b0;
                        state_q <= S_FETCH;
                    end
                end
                S_FAULT: begin
                    valid_q <= 1'b0;
                    state_q <= S_FAULT;
                end
            endcase
        end
    end

    assign mem_addr    = pc_q;
    assign mem_we      = 1'b0;
    assign mem_data    = '0;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign fault       = fault_q;
    assign fault_pc    = fault_pc_q;

endmodule
